alu_cmd_queue: RTL and testbench
================================

// Module: alu_cmd_queue
// PURPOSE
//   Command buffer and issue stage directly upstream of the 16-bit alu (a, b, 4-bit mode, 32-bit y).
//   Accepts {a, b, mode} commands over a valid/ready handshake and queues them in a DEPTH-entry FIFO.
//   Issues one command at a time to the alu and registers alu y as a held result on a valid/ready output.
//   Flags divide/modulo by zero instead of passing the alu's undefined result.
// PARAMETERS
//   DEPTH  4   FIFO entries; must be a power of two, >= 2
//   AW     2   pointer width, log2(DEPTH)
// PORTS
//   clock     in   1   the one clock; all state updates on posedge
//   reset     in   1   reset is synchronous and active-low (0 = reset)
//   in_valid  in   1   command present
//   in_ready  out  1   queue can accept: (count < DEPTH) && reset
//   in_a      in   16  operand a
//   in_b      in   16  operand b
//   in_mode   in   4   alu mode code, 0..15
//   alu_a     out  16  registered operand a to alu
//   alu_b     out  16  registered operand b to alu
//   alu_mode  out  4   registered mode to alu
//   alu_y     in   32  combinational alu result
//   out_valid out  1   result held
//   out_ready in   1   downstream accepts result
//   out_y     out  32  result
//   out_mode  out  4   mode that produced out_y
//   out_dz    out  1   1 = mode 4/5 with b == 0
//   count     out  AW+1  FIFO occupancy, 0..DEPTH
// BEHAVIOUR
//   Reset (reset == 0 at posedge): wr/rd pointers = 0, count = 0, state = IDLE, out_valid = 0,
//     out_y = 0, out_mode = 0, out_dz = 0, alu_a/alu_b/alu_mode = 0. Queued and in-flight commands are discarded.
//   Push: in_valid && in_ready at posedge -> write entry at wr_ptr, wr_ptr += 1 mod DEPTH.
//     No push when full (in_ready = 0); no bypass around the FIFO.
//   Pop: head -> alu_a/alu_b/alu_mode, rd_ptr += 1 mod DEPTH.
//     Push and pop in the same cycle: count unchanged.
//   FSM:
//     IDLE: if count != 0 -> pop, go EXEC; else stay.
//     EXEC: alu settles (one full cycle). At posedge: out_y = alu_y, out_mode = alu_mode,
//       out_dz = 0, out_valid = 1, go WAIT.
//       If alu_mode is 4 or 5 and alu_b == 0: out_y = 32'hFFFF_FFFF, out_dz = 1 instead.
//     WAIT: out_valid = 1; out_y/out_mode/out_dz held stable.
//       On out_valid && out_ready: if count != 0 pop and go EXEC (out_valid drops) else go IDLE, out_valid = 0.
//   Latency: command accepted at edge N into empty idle block -> popped at N+1 -> out_valid high after edge N+2.
//   Throughput: one result per 2 cycles with out_ready held 1.
//   Ordering: results leave strictly in acceptance order.
//   Widths: operands 16-bit, result 32-bit. alu_y is passed through unmodified except in the dz case.
//   Reset mid-operation: any state -> IDLE next edge, out_valid low. No stale result appears after release.
// TESTING
//   1. reset = 0 for 2 cycles with in_valid = 1 -> in_ready = 0, count = 0, out_valid = 0;
//      after release -> in_ready = 1.
//   2. push a = 3, b = 5, mode = 0, out_ready = 1 -> out_valid 2 edges after accept, out_y = 8, out_dz = 0.
//   3. push a = 100, b = 0, mode = 4 -> out_y = 32'hFFFF_FFFF, out_dz = 1, out_mode = 4.
//   4. out_ready = 0, offer 6 commands mode = 15, a = 0..5 -> 5 accepted, count = 4, in_ready = 0.
//      Then out_ready = 1 -> out_y = 1, 2, 3, 4, 5 in order, count returns to 0.
//   5. push a = 16'hFFFF, b = 16'hFFFF, mode = 3 -> out_y = 32'hFFFE_0001.
//   6. reset = 0 for one edge during WAIT with 2 queued -> out_valid = 0, count = 0.
//      No further out_valid without new pushes.

Source files
------------

// File: rtl/alu_cmd_queue.sv
// alu_cmd_queue: FIFO-buffered command issue stage for the alu with held, divide-by-zero-flagged results
module alu_cmd_queue #(
   parameter int DEPTH = 4,
   parameter int AW = 2
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [15:0]   in_a,
   input  logic [15:0]   in_b,
   input  logic [3:0]    in_mode,
   output logic [15:0]   alu_a,
   output logic [15:0]   alu_b,
   output logic [3:0]    alu_mode,
   input  logic [31:0]   alu_y,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [31:0]   out_y,
   output logic [3:0]    out_mode,
   output logic          out_dz,
   output logic [AW:0]   count
);
   typedef enum logic [1:0] {IDLE, EXEC, WAIT} state_t;
   state_t state, state_nx;
   logic [35:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic push, pop, dz;
   assign in_ready = count != (AW+1)'(DEPTH) && reset;
   assign push = in_valid && in_ready;
   assign out_valid = state == WAIT;
   assign dz = (alu_mode == 4'd4 || alu_mode == 4'd5) && alu_b == '0;
   always_comb begin
      pop = count != '0 && (state == IDLE || (state == WAIT && out_ready));
      state_nx = state == EXEC ? WAIT : pop ? EXEC : (state == WAIT && out_ready) ? IDLE : state;
   end
   always_ff @(posedge clock) begin
      if (!reset) begin
         state <= IDLE;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
         alu_a <= '0;
         alu_b <= '0;
         alu_mode <= '0;
         out_y <= '0;
         out_mode <= '0;
         out_dz <= 1'b0;
      end else begin
         state <= state_nx;
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
         if (push) begin
            mem[wr_ptr] <= {in_a, in_b, in_mode};
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            {alu_a, alu_b, alu_mode} <= mem[rd_ptr];
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (state == EXEC) begin
            out_y <= dz ? 32'hFFFF_FFFF : alu_y;
            out_mode <= alu_mode;
            out_dz <= dz;
         end
      end
   end
endmodule

// File: tb/tb_alu_cmd_queue.sv
// tb_alu_cmd_queue: directed checks of alu_cmd_queue against a small behavioural alu
module tb_alu_cmd_queue;
   logic clock = 1'b0, reset = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic in_ready, out_valid, out_dz;
   logic [15:0] in_a = '0, in_b = '0, alu_a, alu_b;
   logic [3:0] in_mode = '0, alu_mode, out_mode;
   logic [31:0] alu_y, out_y;
   logic [2:0] count;
   int checks = 0, errors = 0;
   alu_cmd_queue #(.DEPTH(4), .AW(2)) dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_mode(in_mode),
      .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode), .alu_y(alu_y),
      .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
      .out_mode(out_mode), .out_dz(out_dz), .count(count)
   );
   always #5 clock = ~clock;
   // alu stand-in: only modes 0, 3, 4, 5 and 15 matter to the directed vectors
   always_comb begin
      alu_y = {16'b0, alu_a ^ alu_b};
      case (alu_mode)
         4'd0: alu_y = {16'b0, alu_a} + {16'b0, alu_b};
         4'd3: alu_y = {16'b0, alu_a} * {16'b0, alu_b};
         4'd4: alu_y = alu_b == '0 ? 32'h0 : {16'b0, alu_a / alu_b};
         4'd5: alu_y = alu_b == '0 ? 32'h0 : {16'b0, alu_a % alu_b};
         4'd15: alu_y = {16'b0, alu_a} + 32'd1;
         default: ;
      endcase
   end
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clock);
      #1;
   endtask
   task automatic push_one(input logic [15:0] a, input logic [15:0] b, input logic [3:0] m);
      in_valid = 1'b1;
      in_a = a;
      in_b = b;
      in_mode = m;
      step();
      in_valid = 1'b0;
   endtask
   task automatic wait_valid();
      for (int n = 0; n < 20 && !out_valid; n++) step();
      chk("wait_valid", 32'(out_valid), 32'd1);
   endtask
   task automatic latency_case(input logic [15:0] a, input logic [15:0] b, input logic [3:0] m,
                               input logic [31:0] y, input logic d, input string tag);
      push_one(a, b, m);
      chk({tag, "_n1"}, 32'(out_valid), 32'd0);
      step();
      chk({tag, "_n2"}, 32'(out_valid), 32'd0);
      step();
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_y"}, out_y, y);
      chk({tag, "_dz"}, 32'(out_dz), 32'(d));
      chk({tag, "_mode"}, 32'(out_mode), 32'(m));
      step();
      chk({tag, "_drop"}, 32'(out_valid), 32'd0);
   endtask
   initial begin
      int acc, seen;
      in_valid = 1'b1;
      step();
      step();
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_y", out_y, 32'd0);
      in_valid = 1'b0;
      reset = 1'b1;
      #1;
      chk("rel_in_ready", 32'(in_ready), 32'd1);
      out_ready = 1'b1;
      latency_case(16'd3, 16'd5, 4'd0, 32'd8, 1'b0, "add");
      latency_case(16'd100, 16'd0, 4'd4, 32'hFFFF_FFFF, 1'b1, "div0");
      latency_case(16'd100, 16'd0, 4'd5, 32'hFFFF_FFFF, 1'b1, "mod0");
      latency_case(16'd100, 16'd7, 4'd4, 32'd14, 1'b0, "div");
      out_ready = 1'b0;
      acc = 0;
      for (int i = 0; i < 6; i++) begin
         acc += int'(in_ready);
         in_valid = 1'b1;
         in_a = 16'(i);
         in_b = '0;
         in_mode = 4'd15;
         step();
      end
      in_valid = 1'b0;
      chk("fill_accepted", 32'(acc), 32'd5);
      chk("fill_count", 32'(count), 32'd4);
      chk("fill_in_ready", 32'(in_ready), 32'd0);
      chk("fill_head_y", out_y, 32'd1);
      out_ready = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         wait_valid();
         chk("order_y", out_y, 32'(k));
         chk("order_mode", 32'(out_mode), 32'd15);
         step();
      end
      chk("drain_count", 32'(count), 32'd0);
      chk("drain_valid", 32'(out_valid), 32'd0);
      latency_case(16'hFFFF, 16'hFFFF, 4'd3, 32'hFFFE_0001, 1'b0, "mul");
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_a = 16'(7 + i);
         in_b = 16'd1;
         in_mode = 4'd0;
         step();
      end
      in_valid = 1'b0;
      chk("mid_valid", 32'(out_valid), 32'd1);
      chk("mid_y", out_y, 32'd8);
      chk("mid_count", 32'(count), 32'd2);
      reset = 1'b0;
      step();
      reset = 1'b1;
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_count", 32'(count), 32'd0);
      chk("mid_rst_alu_a", 32'(alu_a), 32'd0);
      out_ready = 1'b1;
      seen = 0;
      for (int n = 0; n < 10; n++) begin
         step();
         seen += int'(out_valid);
      end
      chk("no_stale", 32'(seen), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
   initial begin
      #100000;
      $display("FAIL timeout got running expected finished");
      $fatal(1);
   end
endmodule
